// File: rtl/oven_pkg.sv
// Shared oven controller types and constants.
// Beep state encoding and the default clock rate.
package oven_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2
  } beep_state_t;

  localparam int SECONDS_DFLT = 50_000_000;

endpackage

// File: rtl/oven_beeper_if.sv
// Request/status bundle between oven control and the beeper.
// Optional tone modulation is selected by OVEN_BEEP_TONE_EN.
interface oven_beeper_if;

  logic start;
  logic cancel;
  logic beep;
  logic busy;
  logic done;

  modport master (
    output start,
    output cancel,
    input  beep,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  cancel,
    output beep,
    output busy,
    output done
  );

endinterface

// File: rtl/oven_tone_gen.sv
// Registered square-wave tone, restarting high on each enable rise.
// Only instantiated when OVEN_BEEP_TONE_EN is defined.
module oven_tone_gen #(
  parameter int TONE_HALF = 25_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tone
);

  localparam logic [31:0] HALF_LAST = 32'(TONE_HALF - 1);

  logic [31:0] div_q, div_d;
  logic        run_q, run_d;
  logic        tone_q, tone_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      run_q  <= 1'b0;
      tone_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      run_q  <= run_d;
      tone_q <= tone_d;
    end
  end

  // en is the next-cycle ON flag, so tone_q is valid in the first ON cycle
  always_comb begin
    div_d  = div_q;
    run_d  = run_q;
    tone_d = tone_q;
    if (!en) begin
      div_d  = '0;
      run_d  = 1'b0;
      tone_d = 1'b0;
    end else if (!run_q) begin
      div_d  = '0;
      run_d  = 1'b1;
      tone_d = 1'b1;
    end else if (div_q == HALF_LAST) begin
      div_d  = '0;
      tone_d = ~tone_q;
    end else begin
      div_d  = div_q + 32'd1;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/oven_beeper.sv
// Plays BEEPS on-pulses separated by gaps after a start request.
// Define OVEN_BEEP_TONE_EN to square-wave modulate beep during ON.
module oven_beeper
  import oven_pkg::*;
#(
  parameter int SECONDS   = SECONDS_DFLT,
  parameter int BEEPS     = 3,
  parameter int ON_SEC    = 1,
  parameter int OFF_SEC   = 1,
  parameter int TONE_HALF = 25_000
) (
  input  logic          clk,
  input  logic          rst,
  oven_beeper_if.slave  bus
);

  localparam longint ON_L  = longint'(ON_SEC) * longint'(SECONDS);
  localparam longint OFF_L = longint'(OFF_SEC) * longint'(SECONDS);
  localparam int     CW    = $clog2(BEEPS + 1);

  localparam logic [31:0]   ON_LAST  = 32'(ON_L - 1);
  localparam logic [31:0]   OFF_LAST = 32'(OFF_L - 1);
  localparam logic [CW-1:0] BEEPS_C  = CW'(BEEPS);

  if (BEEPS < 1) begin : g_bad_beeps
    $error("oven_beeper: BEEPS must be >= 1");
  end
  if (ON_SEC < 1 || OFF_SEC < 1 || SECONDS < 1) begin : g_bad_len
    $error("oven_beeper: phase lengths must be >= 1");
  end
  if (ON_L > 64'hFFFF_FFFF || OFF_L > 64'hFFFF_FFFF) begin : g_bad_wide
    $error("oven_beeper: phase length exceeds 32-bit timer");
  end
  if (TONE_HALF < 1) begin : g_bad_tone
    $error("oven_beeper: TONE_HALF must be >= 1");
  end

  beep_state_t   state_q, state_d;
  logic [31:0]   timer_q, timer_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          beep_d;
  logic          on_end, off_end;

  assign on_end  = (timer_q == ON_LAST);
  assign off_end = (timer_q == OFF_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      timer_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = ON;
          timer_d = '0;
          cnt_d   = CW'(1);
        end
      end
      ON: begin
        if (on_end) begin
          timer_d = '0;
          if (cnt_q == BEEPS_C) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            state_d = OFF;
          end
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      OFF: begin
        if (off_end) begin
          state_d = ON;
          timer_d = '0;
          cnt_d   = cnt_q + CW'(1);
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: begin
        state_d = IDLE;
        timer_d = '0;
        cnt_d   = '0;
      end
    endcase
    // cancel overrides everything, including a same-cycle start
    if (bus.cancel) begin
      state_d = IDLE;
      timer_d = '0;
      cnt_d   = '0;
    end
  end

  always_comb begin
    beep_d = (state_d == ON);
    busy_d = (state_d != IDLE);
    done_d = (state_q == ON) && on_end &&
             (cnt_q == BEEPS_C) && !bus.cancel;
  end

`ifdef OVEN_BEEP_TONE_EN
  logic tone;

  oven_tone_gen #(
    .TONE_HALF (TONE_HALF)
  ) u_tone (
    .clk  (clk),
    .rst  (rst),
    .en   (beep_d),
    .tone (tone)
  );

  assign bus.beep = tone;
`else
  logic beep_q;

  always_ff @(posedge clk) begin
    if (!rst) beep_q <= 1'b0;
    else      beep_q <= beep_d;
  end

  assign bus.beep = beep_q;
`endif

  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_oven_beeper.sv
// Directed and random stimulus against a pattern-position model.
// Define OVEN_BEEP_TONE_EN to check the tone build (ON_SEC=2).
module tb_oven_beeper;

  localparam int SEC  = 4;
  localparam int NB   = 2;
  localparam int OFFS = 2;
  localparam int TH   = 1;
`ifdef OVEN_BEEP_TONE_EN
  localparam int ONS  = 2;
`else
  localparam int ONS  = 1;
`endif
  localparam int ONC   = ONS * SEC;
  localparam int OFFC  = OFFS * SEC;
  localparam int PER   = ONC + OFFC;
  localparam int TOTAL = NB * ONC + (NB - 1) * OFFC;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  oven_beeper_if bif ();

  oven_beeper #(
    .SECONDS   (SEC),
    .BEEPS     (NB),
    .ON_SEC    (ONS),
    .OFF_SEC   (OFFS),
    .TONE_HALF (TH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif.slave)
  );

  int total = 0;
  int bad   = 0;
  bit act   = 1'b0;
  int e     = 0;
  bit x_done = 1'b0;
  int busy_n;

  // e = cycle index within the pattern for the current output cycle
  function automatic bit x_beep();
    int p;
    if (!act) return 1'b0;
    p = e % PER;
    if (p >= ONC) return 1'b0;
`ifdef OVEN_BEEP_TONE_EN
    return ((p / TH) % 2) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic check(input string tag);
    bit xb;
    xb = x_beep();
    total++;
    assert (bif.busy === act) else begin
      bad++;
      $error("FAIL %s busy: got %b want %b", tag, bif.busy, act);
    end
    total++;
    assert (bif.beep === xb) else begin
      bad++;
      $error("FAIL %s beep: got %b want %b", tag, bif.beep, xb);
    end
    total++;
    assert (bif.done === x_done) else begin
      bad++;
      $error("FAIL %s done: got %b want %b", tag, bif.done, x_done);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit c,
                      input string tag);
    rst        = r;
    bif.start  = s;
    bif.cancel = c;
    @(posedge clk);
    if (!r || c) begin
      act    = 1'b0;
      x_done = 1'b0;
    end else if (act) begin
      x_done = 1'b0;
      e++;
      if (e == TOTAL) begin
        act    = 1'b0;
        x_done = 1'b1;
      end
    end else begin
      x_done = 1'b0;
      if (s) begin
        act = 1'b1;
        e   = 0;
      end
    end
    #1;
    check(tag);
  endtask

  initial begin
    bif.start  = 1'b0;
    bif.cancel = 1'b0;

    step(0, 0, 0, "reset");
    step(0, 1, 0, "reset_start");
    step(1, 0, 0, "post_reset");

    busy_n = 0;
    step(1, 1, 0, "pat");
    busy_n += int'(bif.busy);
    for (int i = 1; i <= TOTAL + 3; i++) begin
      step(1, 0, 0, "pat");
      busy_n += int'(bif.busy);
    end
    total++;
    assert (busy_n === TOTAL) else begin
      bad++;
      $error("FAIL pat_len: got %0d want %0d", busy_n, TOTAL);
    end

    step(1, 1, 0, "cancel");
    for (int i = 1; i <= 6; i++) step(1, 0, 0, "cancel");
    step(1, 0, 1, "cancel");
    step(1, 0, 0, "cancel");
    step(1, 0, 0, "cancel");
    step(1, 1, 0, "replay");
    for (int i = 0; i < TOTAL + 2; i++) step(1, 0, 0, "replay");

    for (int i = 0; i < TOTAL + 4; i++)
      step(1, (i == 0 || i == 3 || i == 9), 0, "restart_ign");

    step(1, 1, 1, "start_cancel");
    for (int i = 0; i < 5; i++) step(1, 0, 0, "start_cancel");

    for (int i = 0; i < TOTAL + 4; i++)
      step((i != 14), (i == 0), 0, "mid_reset");

    step(1, 1, 0, "done_restart");
    for (int i = 1; i <= TOTAL + 1; i++) step(1, 0, 0, "done_restart");
    step(1, 1, 0, "done_restart");
    for (int i = 0; i < TOTAL + 3; i++) step(1, 0, 0, "done_restart");

    for (int i = 0; i < 1500; i++)
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 49) == 0), "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
